// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, the default reset PC and bubble instruction, and the PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BUBBLE_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INCR             = 32'd4;

    // Redirect targets are word aligned by clearing the two low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding req/gnt + rvalid
// handshake to instruction memory and presents registered pc/inst/inst_valid to IF/ID.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] BUBBLE_INST = DEFAULT_BUBBLE_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_q_r, pc_q_s;
    logic [31:0]  req_pc_r, req_pc_s;
    logic [31:0]  hold_pc_r, hold_pc_s;
    logic [31:0]  hold_inst_r, hold_inst_s;
    logic         hold_valid_r, hold_valid_s;
    logic [31:0]  pc_r, pc_s;
    logic [31:0]  inst_r, inst_s;
    logic         inst_valid_r, inst_valid_s;
    logic         rsp_s;
    logic         req_s;
    logic         fire_s;

    // A response only counts while a live request is outstanding.
    assign rsp_s  = (state_r == WAIT) && imem_rvalid;
    assign req_s  = !br_taken && ((state_r == IDLE) || (rsp_s && !stall));
    assign fire_s = req_s && imem_gnt;

    assign imem_req   = req_s;
    assign imem_addr  = pc_q_r;
    assign pc         = pc_r;
    assign inst       = inst_r;
    assign inst_valid = inst_valid_r;

    // Next-state, PC and hold-buffer logic; a redirect overrides everything else.
    always_comb begin
        state_s      = state_r;
        pc_q_s       = pc_q_r;
        req_pc_s     = req_pc_r;
        hold_pc_s    = hold_pc_r;
        hold_inst_s  = hold_inst_r;
        hold_valid_s = hold_valid_r;
        case (state_r)
            IDLE: begin
                if (fire_s) state_s = WAIT;
                else        state_s = IDLE;
            end
            WAIT: begin
                if (imem_rvalid && !stall) begin
                    state_s = fire_s ? WAIT : IDLE;
                end else if (imem_rvalid) begin
                    state_s      = HOLD;
                    hold_valid_s = 1'b1;
                    hold_pc_s    = req_pc_r;
                    hold_inst_s  = imem_rdata;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_s      = IDLE;
                    hold_valid_s = 1'b0;
                end else begin
                    state_s = HOLD;
                end
            end
            KILL: begin
                if (imem_rvalid) state_s = IDLE;
                else             state_s = KILL;
            end
            default: state_s = IDLE;
        endcase
        if (fire_s) begin
            req_pc_s = pc_q_r;
            pc_q_s   = pc_q_r + PC_INCR;
        end else begin
            req_pc_s = req_pc_r;
        end
        // A request still in flight after the redirect must have its response dropped.
        if (br_taken) begin
            pc_q_s       = align_pc(br_target);
            hold_valid_s = 1'b0;
            if (((state_r == WAIT) || (state_r == KILL)) && !imem_rvalid) state_s = KILL;
            else                                                          state_s = IDLE;
        end else begin
            hold_valid_s = hold_valid_s;
        end
    end

    // Output register selection in priority order: redirect, stall, held entry, live response.
    always_comb begin
        pc_s         = 32'd0;
        inst_s       = BUBBLE_INST;
        inst_valid_s = 1'b0;
        if (br_taken) begin
            pc_s         = 32'd0;
            inst_s       = BUBBLE_INST;
            inst_valid_s = 1'b0;
        end else if (stall) begin
            pc_s         = pc_r;
            inst_s       = inst_r;
            inst_valid_s = inst_valid_r;
        end else if (hold_valid_r) begin
            pc_s         = hold_pc_r;
            inst_s       = hold_inst_r;
            inst_valid_s = 1'b1;
        end else if (rsp_s) begin
            pc_s         = req_pc_r;
            inst_s       = imem_rdata;
            inst_valid_s = 1'b1;
        end else begin
            pc_s         = 32'd0;
            inst_s       = BUBBLE_INST;
            inst_valid_s = 1'b0;
        end
    end

    // State, PC, hold buffer and IF/ID-facing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            pc_q_r       <= RESET_PC;
            req_pc_r     <= 32'd0;
            hold_pc_r    <= 32'd0;
            hold_inst_r  <= 32'd0;
            hold_valid_r <= 1'b0;
            pc_r         <= 32'd0;
            inst_r       <= BUBBLE_INST;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_q_r       <= pc_q_s;
            req_pc_r     <= req_pc_s;
            hold_pc_r    <= hold_pc_s;
            hold_inst_r  <= hold_inst_s;
            hold_valid_r <= hold_valid_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            inst_valid_r <= inst_valid_s;
        end
    end

endmodule
